// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and the receiver state encoding.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values simply move the input one stage down the chain.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages come out of reset at the line's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with a one-entry valid/ready output holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TCW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

  rx_state_e state_q, state_d;

  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic rx_s;
  logic stop_done;
  logic frame_good;
  logic frame_bad;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  // State register for the frame FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the counters and shift register that pace the frame.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    unique case (state_q)
      RX_IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            shift_d[DATA_BITS-1] = rx_s;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = RX_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            state_d    = RX_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Output logic: stop-bit verdict, delivery into the holding register and flag pulses.
  always_comb begin
    stop_done   = (state_q == RX_STOP) && tick && (tick_cnt_q == FULL_LAST);
    frame_good  = stop_done && rx_s;
    frame_bad   = stop_done && !rx_s;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_bad;
    overrun_d   = 1'b0;
    if (frame_good) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // Datapath registers; a reset mid-frame drops everything without raising flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != RX_IDLE);

endmodule
